// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, handshaked imem fetch, freeze/flush to IF/ID.
// Ports: clk, rst, freeze_in, branch_taken_in/addr_in, imem_*, PC_out,
//        Instruction_out, freeze_out, flush_out.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_addr_in,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction_out,
  output logic        freeze_out,
  output logic        flush_out
);

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_held;
  logic [31:0] w_held_nxt;
  logic        r_rpend;
  logic        w_rpend_nxt;
  logic [31:0] r_raddr;
  logic [31:0] w_raddr_nxt;

  logic        w_fetch;
  logic        w_hold;
  logic        w_fetch_ok;
  logic        w_avail;
  logic        w_drop;
  logic [31:0] w_pc_inc;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_hold     = (r_state == S_HOLD);
  assign w_fetch_ok = w_fetch && imem_ready && !r_rpend;
  assign w_avail    = w_fetch_ok || w_hold;
  // Word completing an access that a redirect already superseded.
  assign w_drop     = w_fetch && imem_ready && r_rpend;
  assign w_pc_inc   = r_pc + 32'd4;

  assign imem_req  = w_fetch && !rst;
  assign imem_addr = r_pc;
  assign PC_out    = w_pc_inc;

  always_comb begin
    Instruction_out = NOP_INSTR;
    freeze_out      = 1'b0;
    flush_out       = 1'b0;
    if (rst) begin
      freeze_out = 1'b1;
    end else if (branch_taken_in || w_drop) begin
      flush_out = 1'b1;
    end else begin
      if (w_hold)
        Instruction_out = r_held;
      else if (w_fetch_ok)
        Instruction_out = imem_rdata;
      freeze_out = freeze_in || !w_avail;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_held_nxt  = r_held;
    w_rpend_nxt = r_rpend;
    w_raddr_nxt = r_raddr;
    if (branch_taken_in && w_fetch && !imem_ready) begin
      // Keep imem_addr stable; redirect once the access completes.
      w_rpend_nxt = 1'b1;
      w_raddr_nxt = branch_addr_in;
    end else if (branch_taken_in) begin
      w_pc_nxt    = branch_addr_in;
      w_state_nxt = S_FETCH;
      w_rpend_nxt = 1'b0;
    end else if (w_drop) begin
      w_pc_nxt    = r_raddr;
      w_rpend_nxt = 1'b0;
    end else if (w_fetch && imem_ready && !freeze_in) begin
      w_pc_nxt = w_pc_inc;
    end else if (w_fetch && imem_ready) begin
      // Capture so memory is not asked again while frozen.
      w_held_nxt  = imem_rdata;
      w_state_nxt = S_HOLD;
    end else if (w_hold && !freeze_in) begin
      w_pc_nxt    = w_pc_inc;
      w_state_nxt = S_FETCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_held  <= 32'h0;
      r_rpend <= 1'b0;
      r_raddr <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_held  <= w_held_nxt;
      r_rpend <= w_rpend_nxt;
      r_raddr <= w_raddr_nxt;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: memory model with wait states plus a
// scoreboard of consumed (instruction, PC+4) pairs.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze_in;
  logic        branch_taken_in;
  logic [31:0] branch_addr_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        freeze_out;
  logic        flush_out;

  logic        one = 1'b1;
  logic [31:0] zero32 = 32'h0;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] PC_out2;
  logic [31:0] instr2;
  logic        freeze2;
  logic        flush2;

  int n_vec = 0;
  int n_err = 0;
  int nwait = 0;
  int mem_cnt = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .freeze_in(freeze_in),
    .branch_taken_in(branch_taken_in), .branch_addr_in(branch_addr_in),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .PC_out(PC_out), .Instruction_out(Instruction_out),
    .freeze_out(freeze_out), .flush_out(flush_out)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .freeze_in(1'b0),
    .branch_taken_in(1'b0), .branch_addr_in(zero32),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(zero32), .imem_ready(one),
    .PC_out(PC_out2), .Instruction_out(instr2),
    .freeze_out(freeze2), .flush_out(flush2)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'hE000_0000 + {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = rom(a);
    e.pc4   = a + 32'd4;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic fr, input logic br,
                     input logic [31:0] ba, input logic r);
    exp_t e;
    @(negedge clk);
    freeze_in       = fr;
    branch_taken_in = br;
    branch_addr_in  = ba;
    rst             = r;
    imem_ready      = (mem_cnt >= nwait);
    #1;
    imem_rdata = rom(imem_addr);
    #1;
    if (!rst && !freeze_out && !flush_out) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", Instruction_out, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", Instruction_out, e.instr);
        chk("sb_pc", PC_out, e.pc4);
      end
    end
    if (rst)
      mem_cnt = 0;
    else if (imem_req && imem_ready)
      mem_cnt = 0;
    else if (imem_req)
      mem_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    freeze_in = 1'b0;
    branch_taken_in = 1'b0;
    branch_addr_in = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;

    // Reset state
    cyc(0, 0, 0, 1);
    chk("rst_req", imem_req, 0);
    chk("rst_frz", freeze_out, 1);
    chk("rst_flush", flush_out, 0);
    chk("rst_instr", Instruction_out, 32'h0);
    chk("rst_pc", PC_out, 32'h4);
    chk("rst2_pc", PC_out2, 32'h0);
    chk("rst2_req", imem_req2, 0);

    // Zero-wait streaming
    nwait = 0;
    for (int i = 0; i < 5; i++) push(32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("zw_frz", freeze_out, 0);
      if (i == 0) chk("wrap_addr0", imem_addr2, 32'hFFFF_FFFC);
      if (i == 1) chk("wrap_addr1", imem_addr2, 32'h0);
    end
    chk("zw_drain", sb.size(), 0);

    // Two wait states per access
    nwait = 2;
    for (int k = 0; k < 3; k++) push(32'(20 + 4 * k));
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) begin
        cyc(0, 0, 0, 0);
        chk("ws_addr", imem_addr, 32'(20 + 4 * k));
        if (c != 2) begin
          chk("ws_frz", freeze_out, 1);
          chk("ws_nop", Instruction_out, 32'h0);
        end
      end
    end
    chk("ws_drain", sb.size(), 0);

    // Freeze while word at pc=8 returns
    nwait = 0;
    cyc(0, 0, 0, 1);
    push(32'h0);
    push(32'h4);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(1, 0, 0, 0);
      chk("hold_instr", Instruction_out, 32'hE000_0002);
      chk("hold_frz", freeze_out, 1);
      if (c > 0) chk("hold_noreq", imem_req, 0);
    end
    push(32'h8);
    push(32'hC);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hold_next_addr", imem_addr, 32'hC);
    chk("hold_drain", sb.size(), 0);

    // Branch with ready memory, then with concurrent freeze
    for (int f = 0; f < 2; f++) begin
      cyc(f[0], 1, 32'h100, 0);
      chk("br_flush", flush_out, 1);
      chk("br_frz", freeze_out, 0);
      chk("br_nop", Instruction_out, 32'h0);
      push(32'h100);
      cyc(0, 0, 0, 0);
      chk("br_addr", imem_addr, 32'h100);
      chk("br_pc", PC_out, 32'h104);
    end
    chk("br_drain", sb.size(), 0);

    // Branch during an outstanding fetch
    nwait = 2;
    cyc(0, 1, 32'h200, 0);
    chk("bw_flush0", flush_out, 1);
    chk("bw_addr0", imem_addr, 32'h104);
    cyc(0, 0, 0, 0);
    chk("bw_frz1", freeze_out, 1);
    chk("bw_addr1", imem_addr, 32'h104);
    cyc(0, 0, 0, 0);
    chk("bw_rdy2", imem_ready, 1);
    chk("bw_flush2", flush_out, 1);
    chk("bw_nop2", Instruction_out, 32'h0);
    chk("bw_addr2", imem_addr, 32'h104);
    push(32'h200);
    cyc(0, 0, 0, 0);
    chk("bw_addr3", imem_addr, 32'h200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("bw_drain", sb.size(), 0);

    // Reset in the middle of a wait
    cyc(0, 0, 0, 0);
    chk("rw_wait", freeze_out, 1);
    cyc(0, 0, 0, 1);
    chk("rw_req", imem_req, 0);
    chk("rw_pc", PC_out, 32'h4);
    nwait = 0;
    push(32'h0);
    cyc(0, 0, 0, 0);
    chk("rw_addr", imem_addr, 32'h0);
    chk("rw_drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage ARM pipeline. Holds the program counter, fetches one 32-bit instruction per cycle over a ready-handshaked instruction-memory port, and presents PC+4, the instruction, and the freeze/flush qualifiers to the IF/ID pipeline register directly downstream. It absorbs memory wait states, hazard-unit freezes and EXE-stage branch redirects, including redirects that arrive while a fetch is outstanding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word emitted in bubble/discarded slots.

- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- freeze_in  in  1  hazard-unit stall; hold current instruction, do not advance PC
- branch_taken_in  in  1  EXE-stage redirect, single-cycle pulse
- branch_addr_in  in  32  redirect target, valid with branch_taken_in
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address (= pc), stable while imem_req high and imem_ready low
- imem_rdata  in  32  instruction word, valid in the cycle imem_ready is high
- imem_ready  in  1  memory completes the request this cycle (may stay low any number of cycles)
- PC_out  out  32  pc + 4 (mod 2^32) of the presented instruction
- Instruction_out  out  32  presented instruction
- freeze_out  out  1  presented slot is not to be consumed this cycle
- flush_out  out  1  presented slot is a discarded wrong-path slot

## Operation
- State: pc[31:0], state {FETCH, HOLD}, held_instr[31:0], redirect_pending, redirect_addr[31:0].
- imem_req = (state==FETCH) && !rst; imem_addr = pc.
- fetch_ok = FETCH && imem_ready && !redirect_pending; avail = fetch_ok || HOLD.
- Outputs (combinational), in priority:
  - rst high: Instruction_out=NOP_INSTR, freeze_out=1, flush_out=0.
  - branch_taken_in, or (FETCH && imem_ready && redirect_pending): Instruction_out=NOP_INSTR, flush_out=1, freeze_out=0.
  - otherwise: Instruction_out = HOLD ? held_instr : (fetch_ok ? imem_rdata : NOP_INSTR); flush_out=0; freeze_out = freeze_in || !avail.
- PC_out = pc + 4 always; 32-bit add, carry discarded (pc 32'hFFFF_FFFC -> 32'h0000_0000).
- Next-state, first matching rule wins:
  1. branch_taken_in && FETCH && !imem_ready: pc held (address stability), redirect_pending<=1, redirect_addr<=branch_addr_in (a later branch overwrites it).
  2. branch_taken_in (any other case): pc<=branch_addr_in, state<=FETCH, redirect_pending<=0; fetched/held word discarded. Branch overrides freeze_in.
  3. FETCH && imem_ready && redirect_pending: pc<=redirect_addr, redirect_pending<=0; returned word discarded.
  4. FETCH && imem_ready && !freeze_in: pc<=pc+4.
  5. FETCH && imem_ready && freeze_in: held_instr<=imem_rdata, state<=HOLD; pc held.
  6. HOLD && !freeze_in: pc<=pc+4, state<=FETCH.
  7. Otherwise (FETCH waiting, HOLD frozen): no change.
- Memory is never re-requested for a word already captured in HOLD.

## Timing
- Reset (async, immediate): pc=RESET_PC, state=FETCH, redirect_pending=0, redirect_addr=0, held_instr=0; outputs as in rst rule; PC_out=RESET_PC+4.
- First request in the first cycle after rst deasserts.
- Zero-wait memory (imem_ready tied high): one instruction per cycle, freeze_out=0, combinational rdata-to-Instruction_out path.
- Each wait cycle yields one freeze_out=1 bubble with Instruction_out=NOP_INSTR.
- Redirect latency: branch at edge N -> target fetched from cycle N+1 (ready case) or the cycle after the outstanding request completes (pending case).
- Reset mid-wait or mid-HOLD discards everything; no request issued while rst high.

## Test plan
- Zero-wait: ROM[i]=32'hE000_0000+i, imem_ready=1 -> Instruction_out E000_0000, E000_0001, ... on consecutive cycles, PC_out 4, 8, 12, freeze_out=0.
- Two wait states per access -> each instruction preceded by 2 cycles of freeze_out=1/NOP; imem_addr stable across wait; PC_out sequence unchanged.
- freeze_in high 3 cycles as word at pc=8 returns -> HOLD presents that word for 3 cycles with freeze_out=1, no new imem_req; on release pc=12 fetched next.
- branch_taken_in with branch_addr_in=32'h100, imem_ready=1 -> that cycle flush_out=1/NOP; next imem_addr=32'h100, PC_out=32'h104; also with freeze_in=1 concurrently: same result.
- branch during wait (target 32'h200), ready 2 cycles later -> imem_addr held at old pc, returned word emitted with flush_out=1, then imem_addr=32'h200.
- RESET_PC=32'hFFFF_FFFC -> PC_out=0, next imem_addr=0; assert rst mid-wait -> imem_req=0 immediately, restart at RESET_PC.
